// File: rtl/commit_trace_buffer_if.sv
// Bundles the core's commit/memory observation strobes and the trace sink handshake.
// The master drives the events and the sink's ready; the slave (trace buffer) returns the entries.
interface commit_trace_buffer_if #(
    parameter int DATA_W = 32,
    parameter int TS_W   = 16
);
    localparam int ENTRY_W = 2 + 9 + DATA_W + TS_W;

    logic                reg_write_sig;
    logic [4:0]          reg_num;
    logic [DATA_W-1:0]   reg_data;
    logic                wr;
    logic                rd;
    logic [8:0]          addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   rd_data;
    logic                trace_valid;
    logic                trace_ready;
    logic [ENTRY_W-1:0]  trace_data;

    modport master (
        output reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data, trace_ready,
        input  trace_valid, trace_data
    );

    modport slave (
        input  reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data, trace_ready,
        output trace_valid, trace_data
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Timestamps register write-backs and data-memory accesses into a FIFO drained by a valid/ready sink.
// Never stalls the core: events that do not fit are dropped and counted.
module commit_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int TS_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trace_en_i,
    input  logic                   drop_clr_i,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic                   overflow_o,
    output logic [15:0]            drop_count_o,
    commit_trace_buffer_if.slave   trace_if
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 + 9 + DATA_W + TS_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
    logic [CNT_W-1:0]   count_q, count_d, space;
    logic [TS_W-1:0]    stamp_q;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               ovf_q, ovf_d;
    logic [16:0]        drop_sum;

    logic               mem_ev, reg_ev, pop;
    logic [1:0]         n_ev, n_push, n_drop;
    logic [ENTRY_W-1:0] mem_entry, reg_entry, slot0;

    always_comb begin
        mem_ev    = trace_en_i & (trace_if.wr | trace_if.rd);
        reg_ev    = trace_en_i & trace_if.reg_write_sig & (trace_if.reg_num != 5'd0);
        mem_entry = {trace_if.wr ? 2'b10 : 2'b11, trace_if.addr,
                     trace_if.wr ? trace_if.wr_data : trace_if.rd_data, stamp_q};
        reg_entry = {2'b01, 4'b0000, trace_if.reg_num, trace_if.reg_data, stamp_q};
        slot0     = mem_ev ? mem_entry : reg_entry;

        // Room is judged before this cycle's pop; the memory event claims the first free slot.
        space = CNT_W'(DEPTH) - count_q;
        n_ev  = {1'b0, mem_ev} + {1'b0, reg_ev};
        if (space >= CNT_W'(n_ev)) begin
            n_push = n_ev;
        end else begin
            n_push = space[1:0];
        end
        n_drop = n_ev - n_push;

        pop       = (count_q != '0) & trace_if.trace_ready;
        count_d   = count_q + CNT_W'(n_push) - CNT_W'(pop);
        wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
        wr_ptr_d  = wr_ptr_q + PTR_W'(n_push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);

        drop_sum = {1'b0, drop_cnt_q} + 17'(n_drop);
        if (drop_clr_i) begin
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            ovf_d      = ovf_q | (n_drop != 2'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stamp_q    <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stamp_q    <= stamp_q + TS_W'(1);
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (n_push != 2'd0) begin
            mem_q[wr_ptr_q] <= slot0;
        end
        if (n_push == 2'd2) begin
            mem_q[wr_ptr_p1] <= reg_entry;
        end
    end

    assign trace_if.trace_valid = (count_q != '0);
    assign trace_if.trace_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign fifo_count_o         = count_q;
    assign overflow_o           = ovf_q;
    assign drop_count_o         = drop_cnt_q;
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the riscv core top. Consumes its write-back and data-memory observation outputs: reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data.
- Packs each architectural event into a timestamped trace entry and buffers it in a FIFO.
- Drains entries over a valid/ready interface to a trace sink (UART bridge or bench scoreboard).
- Does not back-pressure the core. When there is no room, entries are dropped and the drop is counted.

Parameters:
DEPTH, 16, FIFO entries; power of two, ≥4
DATA_W, 32, data field width; matches core DATA_W
TS_W, 16, timestamp width
ENTRY_W, 2+9+DATA_W+TS_W (=59), derived; not overridable

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
trace_en  input  1  capture enable
reg_write_sig  input  1  core register write strobe
reg_num  input  5  destination register
reg_data  input  32  write-back data
wr  input  1  data-memory store strobe
rd  input  1  data-memory load strobe
addr  input  9  data-memory address
wr_data  input  DATA_W  store data
rd_data  input  DATA_W  load data
trace_valid  output  1  head entry available
trace_ready  input  1  sink accepts head entry
trace_data  output  ENTRY_W  {type[1:0], tag[8:0], data[DATA_W-1:0], stamp[TS_W-1:0]}
fifo_count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky, set on any drop
drop_count  output  16  saturating dropped-entry count
drop_clr  input  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset (async assert, released sync to clk): FIFO empty, rd/wr pointers 0, stamp 0, trace_valid 0, trace_data 0, fifo_count 0, overflow 0, drop_count 0.
- Stamp:
  - Free-running TS_W counter, +1 every cycle, wraps from all-ones to 0.
  - Counts regardless of trace_en.
  - An entry carries the stamp value of its capture cycle.
- Event decode, sampled each cycle while trace_en=1:
  - Memory event: type=2'b10 if wr; else type=2'b11 if rd. wr takes precedence when wr&rd, and the load is then ignored (not counted as a drop). tag=addr. data=wr_data for a store, rd_data for a load.
  - Register event: type=2'b01 when reg_write_sig && reg_num!=0. tag={4'b0,reg_num}. data=reg_data. Writes to x0 are never captured.
  - type 2'b00 is never produced.
- Dual push:
  - Up to 2 entries per cycle. The memory event is written first (lower slot), the register event second.
  - Free space is DEPTH − fifo_count taken before this cycle's pop; a same-cycle pop does not create room.
- Drops:
  - If space < number of events, the memory event is kept first and the register event is dropped.
  - If space=0, both are dropped.
  - Each dropped entry increments drop_count, which saturates at 16'hFFFF. overflow is set.
- Pop:
  - trace_valid = (fifo_count!=0).
  - trace_data presents the head entry combinationally from the FIFO array. It is 0 when empty.
  - Handshake occurs when trace_valid&&trace_ready; the head advances on that edge.
  - trace_data must stay stable while trace_valid=1 and trace_ready=0.
  - Pop while empty is ignored.
- Occupancy: fifo_count(next) = fifo_count + pushes − pop. Push and pop in the same cycle are legal. Pointers wrap modulo DEPTH.
- drop_clr:
  - Clears overflow and drop_count on the next edge.
  - Drops in that same cycle are lost from the count; clear wins.
- trace_en=0: no pushes and no drops. Draining continues.
- Reset mid-operation: all buffered entries are discarded immediately. trace_valid falls asynchronously with reset.

Test Plan:
- Reset then idle 5 cycles with trace_en=1 and no strobes -> trace_valid=0, fifo_count=0, drop_count=0, the stamp wraps only after 2^16 cycles.
- reg_write_sig=1, reg_num=5, reg_data=0xDEADBEEF at stamp 3; trace_ready=1 -> the next cycle has trace_valid=1 with type=01, tag=5, data=0xDEADBEEF, stamp=3. The reg_num=0 write at stamp 4 produces no entry.
- Same cycle wr=1, addr=0x1A4, wr_data=0x12345678 plus a reg write r7=0x1 -> fifo_count=2. The first pop returns type=10/tag=0x1A4, the second returns type=01/tag=7. With wr=rd=1, only the type-10 store entry is captured.
- trace_ready=0, fill with 16 reg writes, then one cycle of store+reg write -> both events dropped, drop_count=2, overflow=1. Then at fifo_count=15, store+reg write -> store kept, reg dropped, drop_count=3.
- Full FIFO with trace_ready=1 and a simultaneous reg write -> the pop occurs, the push is dropped, fifo_count=15, drop_count+1. Assert drop_clr -> overflow=0, drop_count=0 next cycle.
- Assert reset asynchronously mid-drain with fifo_count=6 -> trace_valid, fifo_count, and trace_data go to 0 without waiting for a clock edge. After release, the first capture has a stamp counting from 0.
